// File: rtl/p2s_tx_sched_pkg.sv
// Shared types and helpers for the round-robin parallel-to-serial transmit scheduler.
package p2s_tx_sched_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StGap   = 2'd2
   } state_e;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/p2s_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after rr_ptr, wrapping modulo NREQ.
module p2s_rr_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]          req,
   input  logic [$clog2(NREQ)-1:0]  rr_ptr,
   output logic [NREQ-1:0]          gnt,
   output logic [$clog2(NREQ)-1:0]  gnt_idx,
   output logic                     any
);

   localparam int unsigned IDX_W = $clog2(NREQ);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = IDX_W'((32'(rr_ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/p2s_tx_sched.sv
// Shares one MSB-first shifter among NREQ requesters with round-robin grant,
// framing tags (valid/sof/src) and a programmable inter-word gap.
module p2s_tx_sched
   import p2s_tx_sched_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned GAP_CYC = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    data,
   output logic [NREQ-1:0]          ack,
   output logic                     ser_out,
   output logic                     ser_valid,
   output logic                     ser_sof,
   output logic [$clog2(NREQ)-1:0]  ser_src,
   output logic                     busy
);

   localparam int unsigned IDX_W = $clog2(NREQ);
   localparam int unsigned BIT_W = cnt_w(WIDTH);
   localparam int unsigned GAP_W = cnt_w(GAP_CYC + 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   shift_q;
   logic [BIT_W-1:0]   bit_q;
   logic [GAP_W-1:0]   gap_q;
   logic [IDX_W-1:0]   src_q, ptr_q;
   logic [NREQ-1:0]    ack_q;

   logic [NREQ-1:0]    gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               any;
   logic [WIDTH-1:0]   sel_word;
   logic               last_bit, gap_done;

   p2s_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req     (req),
      .rr_ptr  (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   // One-hot grant makes the word select a plain AND-OR mux.
   always_comb begin
      sel_word = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) sel_word = data[i*WIDTH +: WIDTH];
      end
   end

   assign last_bit = (bit_q == BIT_W'(WIDTH - 1));
   assign gap_done = (GAP_CYC == 0) || (32'(gap_q) == GAP_CYC - 1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= StIdle;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any) state_d = StShift;
         StShift: if (last_bit) state_d = (GAP_CYC > 0) ? StGap : StIdle;
         StGap:   if (gap_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         src_q   <= '0;
         ptr_q   <= IDX_W'(NREQ - 1);
         ack_q   <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            StIdle: begin
               if (any) begin
                  shift_q <= sel_word;
                  src_q   <= gnt_idx;
                  ptr_q   <= gnt_idx;
                  ack_q   <= gnt;
                  bit_q   <= '0;
               end
            end
            StShift: begin
               shift_q <= {shift_q[WIDTH-2:0], 1'b0};
               if (!last_bit) bit_q <= bit_q + BIT_W'(1);
               else           gap_q <= '0;
            end
            StGap: begin
               if (!gap_done) gap_q <= gap_q + GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ser_valid = (state_q == StShift);
      ser_out   = ser_valid & shift_q[WIDTH-1];
      ser_sof   = ser_valid & (bit_q == '0);
      ser_src   = src_q;
      ack       = ack_q;
      busy      = (state_q != StIdle);
   end

endmodule

// File: tb/tb_p2s_tx_sched.sv
// Directed bench for p2s_tx_sched: a GAP_CYC=1 instance and a GAP_CYC=0 instance.
module tb_p2s_tx_sched;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [3:0]  req, ack, req_b, ack_b;
   logic [31:0] data, data_b;
   logic        ser_out, ser_valid, ser_sof, busy;
   logic        out_b, valid_b, sof_b, busy_b;
   logic [1:0]  ser_src, src_b;

   int n_tests = 0;
   int n_fail  = 0;

   p2s_tx_sched #(.NREQ(4), .WIDTH(8), .GAP_CYC(1)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .ser_out(ser_out),
      .ser_valid(ser_valid), .ser_sof(ser_sof), .ser_src(ser_src), .busy(busy)
   );

   p2s_tx_sched #(.NREQ(4), .WIDTH(8), .GAP_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .req(req_b), .data(data_b), .ack(ack_b), .ser_out(out_b),
      .ser_valid(valid_b), .ser_sof(sof_b), .ser_src(src_b), .busy(busy_b)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      rst = 1'b0; req = '0; req_b = '0; data = '0; data_b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Waits (bounded) for a word on dut and collects it; src=-1 means timeout.
   task automatic get_word(input bit drop, output int src, output logic [7:0] w,
                           output int nvalid, output int nsof, output logic [3:0] ack0,
                           output int t0);
      int n;
      n = 0; src = -1; w = '0; nvalid = 0; nsof = 0; ack0 = '0; t0 = -1;
      while (!(ser_valid === 1'b1 && ser_sof === 1'b1) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) return;
      t0 = cyc; src = int'(ser_src); ack0 = ack;
      if (drop) req[ser_src] = 1'b0;
      while (ser_valid === 1'b1 && nvalid < 16) begin
         w = {w[6:0], ser_out};
         nvalid++;
         if (ser_sof === 1'b1) nsof++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; req = '0; req_b = '0; data = '0; data_b = '0;
      #1;
      n_tests++;
      if ({ack, ser_out, ser_valid, ser_sof, ser_src, busy} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %0h, expected 0",
                  {ack, ser_out, ser_valid, ser_sof, ser_src, busy});
      end
      n_tests++;
      if ({ack_b, out_b, valid_b, sof_b, src_b, busy_b} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_gap0: got %0h, expected 0",
                  {ack_b, out_b, valid_b, sof_b, src_b, busy_b});
      end
      apply_reset();
   endtask

   task automatic test_single();
      int src, nv, ns, t0, treq;
      logic [7:0] w;
      logic [3:0] a0;
      @(negedge clk);
      data[7:0] = 8'hA5; req = 4'b0001; treq = cyc;
      get_word(1'b1, src, w, nv, ns, a0, t0);
      n_tests++;
      if (src !== 0) begin n_fail++; $display("FAIL single_src: got %0d, expected 0", src); end
      n_tests++;
      if (w !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %0h, expected a5", w); end
      n_tests++;
      if (nv !== 8) begin n_fail++; $display("FAIL single_nvalid: got %0d, expected 8", nv); end
      n_tests++;
      if (ns !== 1) begin n_fail++; $display("FAIL single_sof: got %0d, expected 1", ns); end
      n_tests++;
      if (a0 !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b, expected 0001", a0); end
      n_tests++;
      if (t0 - treq !== 1) begin
         n_fail++; $display("FAIL single_latency: got %0d, expected 1", t0 - treq);
      end
      n_tests++;
      if ({busy, ser_valid, ser_out, ser_sof} !== 4'b1000) begin
         n_fail++; $display("FAIL single_gap: got %b, expected 1000", {busy, ser_valid, ser_out, ser_sof});
      end
      @(negedge clk);
      n_tests++;
      if ({busy, ack} !== 5'b0) begin
         n_fail++; $display("FAIL single_idle: got %b, expected 00000", {busy, ack});
      end
   endtask

   task automatic test_round_robin();
      int src, nv, ns, t0, prev_t0, exp_src;
      int exp_order[6] = '{0, 1, 2, 3, 0, 3};
      logic [7:0] w;
      logic [3:0] a0;
      apply_reset();
      data = {8'h08, 8'h04, 8'h02, 8'h01};
      req = 4'b1111;
      prev_t0 = 0;
      for (int i = 0; i < 6; i++) begin
         get_word(1'b0, src, w, nv, ns, a0, t0);
         exp_src = exp_order[i];
         if (i == 3) req = 4'b1001;
         if (i == 5) req = 4'b0000;
         n_tests++;
         if (src !== exp_src) begin
            n_fail++; $display("FAIL rr_src[%0d]: got %0d, expected %0d", i, src, exp_src);
         end
         n_tests++;
         if (w !== 8'(1 << exp_src) || nv !== 8 || a0 !== 4'(1 << exp_src)) begin
            n_fail++;
            $display("FAIL rr_word[%0d]: got data %0h nvalid %0d ack %b, expected %0h 8 %b",
                     i, w, nv, a0, 8'(1 << exp_src), 4'(1 << exp_src));
         end
         if (i > 0) begin
            n_tests++;
            if (t0 - prev_t0 !== 10) begin
               n_fail++; $display("FAIL rr_spacing[%0d]: got %0d, expected 10", i, t0 - prev_t0);
            end
         end
         prev_t0 = t0;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n, src, nv, ns, t0, bad;
      logic [7:0] w;
      logic [3:0] a0;
      data[7:0] = 8'hFF; req = 4'b0001;
      n = 0;
      while (ser_sof !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      n_tests++;
      if (n >= 40) begin n_fail++; $display("FAIL rstmid_start: got timeout, expected sof"); end
      req[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if ({ack, ser_out, ser_valid, ser_sof, ser_src, busy} !== 10'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got %0h, expected 0",
                  {ack, ser_out, ser_valid, ser_sof, ser_src, busy});
      end
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (ser_valid !== 1'b0 || ack !== 4'b0) bad++;
      end
      rst = 1'b1;
      data[23:16] = 8'h3C; req = 4'b0100;
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL rstmid_held: got %0d active cycles, expected 0", bad); end
      get_word(1'b1, src, w, nv, ns, a0, t0);
      n_tests++;
      if (src !== 2 || w !== 8'h3C || nv !== 8 || a0 !== 4'b0100) begin
         n_fail++;
         $display("FAIL rstmid_after: got src %0d data %0h nvalid %0d ack %b, expected 2 3c 8 0100",
                  src, w, nv, a0);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_late_request();
      int n, nv, ns, na1;
      data[7:0] = 8'h5A; data[15:8] = 8'h77; req = 4'b0001;
      n = 0;
      while (ser_sof !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      n_tests++;
      if (n >= 40) begin n_fail++; $display("FAIL late_start: got timeout, expected sof"); end
      req[0] = 1'b0;
      @(negedge clk);
      req[1] = 1'b1;
      @(negedge clk);
      req[1] = 1'b0;
      nv = 0; ns = 0; na1 = 0;
      for (int k = 0; k < 30; k++) begin
         if (ser_valid === 1'b1) nv++;
         if (ser_sof === 1'b1) ns++;
         if (ack[1] === 1'b1) na1++;
         @(negedge clk);
      end
      n_tests++;
      if (nv !== 6 || ns !== 0) begin
         n_fail++; $display("FAIL late_extra_word: got valid %0d sof %0d, expected 6 0", nv, ns);
      end
      n_tests++;
      if (na1 !== 0) begin n_fail++; $display("FAIL late_ack: got %0d acks, expected 0", na1); end
   endtask

   task automatic test_gap0();
      logic [39:0] vv, ss, bb;
      int srcv[40];
      int first, errs, nvalid;
      logic [7:0] w0, w1;
      bit exp_v, exp_s;
      data_b = {16'h0, 8'h81, 8'hC3};
      req_b = 4'b0011;
      for (int k = 0; k < 40; k++) begin
         vv[k] = valid_b; ss[k] = sof_b; bb[k] = out_b; srcv[k] = int'(src_b);
         if (ack_b[0] === 1'b1) req_b[0] = 1'b0;
         if (ack_b[1] === 1'b1) req_b[1] = 1'b0;
         @(negedge clk);
      end
      first = -1; nvalid = 0;
      for (int k = 39; k >= 0; k--) if (vv[k] === 1'b1) first = k;
      for (int k = 0; k < 40; k++) if (vv[k] === 1'b1) nvalid++;
      n_tests++;
      if (first !== 1) begin n_fail++; $display("FAIL gap0_first: got %0d, expected 1", first); end
      n_tests++;
      if (nvalid !== 16) begin n_fail++; $display("FAIL gap0_nvalid: got %0d, expected 16", nvalid); end
      errs = 0;
      for (int k = 0; k < 40; k++) begin
         exp_v = (k >= 1 && k <= 8) || (k >= 10 && k <= 17);
         exp_s = (k == 1) || (k == 10);
         if (vv[k] !== exp_v || ss[k] !== exp_s) errs++;
      end
      n_tests++;
      if (errs !== 0) begin n_fail++; $display("FAIL gap0_pattern: got %0d bad cycles, expected 0", errs); end
      for (int k = 0; k < 8; k++) begin
         w0[7-k] = bb[1+k];
         w1[7-k] = bb[10+k];
      end
      n_tests++;
      if (w0 !== 8'hC3 || srcv[1] !== 0) begin
         n_fail++; $display("FAIL gap0_word0: got %0h src %0d, expected c3 0", w0, srcv[1]);
      end
      n_tests++;
      if (w1 !== 8'h81 || srcv[10] !== 1) begin
         n_fail++; $display("FAIL gap0_word1: got %0h src %0d, expected 81 1", w1, srcv[10]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_reset_mid();
      test_late_request();
      test_gap0();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
